div_clk_monitor: RTL

//  Consumer side of the clock divider: takes one divided-clock level (fall/digit/1 Hz) back into clk domain.

---
 rtl/div_clk_monitor.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/div_clk_monitor.sv
// div_clk_monitor
//   Brings one divided-clock level (fall/digit/1 Hz tick) back into the clk domain.
//   It synchronises the level, turns its edges into 1-cycle enables, measures the
//   rise-to-rise period, declares lock when the period stays in tolerance, and flags
//   stuck when rises stop arriving. Downstream logic uses rise_pulse as a clock enable.
//
//   Optional feature: define DIV_CLK_MONITOR_DUTY_EN to build the high-time counter.
//   Without it, high_time is tied to 0.
//
// Ports
//   clk           in   1      system clock
//   rst_n         in   1      asynchronous reset, active low
//   div_in        in   1      divided clock level, asynchronous to clk
//   clear         in   1      synchronous soft reset, same effect as rst_n
//   rise_pulse    out  1      1-cycle pulse per synchronised rising edge
//   fall_pulse    out  1      1-cycle pulse per synchronised falling edge
//   period        out  CNT_W  last measured rise-to-rise period in clk cycles
//   period_valid  out  1      1-cycle strobe when period updates
//   locked        out  1      LOCK_COUNT consecutive in-range periods seen
//   stuck         out  1      no rise for TIMEOUT cycles
//   high_time     out  CNT_W  last measured high time (0 unless DIV_CLK_MONITOR_DUTY_EN)
module div_clk_monitor #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned EXPECTED_PERIOD = 8000000,
    parameter int unsigned TOLERANCE       = 16,
    parameter int unsigned LOCK_COUNT      = 2,
    parameter int unsigned TIMEOUT         = 16000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_in,
    input  logic             clear,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             stuck,
    output logic [CNT_W-1:0] high_time
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned LO_P   = (EXPECTED_PERIOD > TOLERANCE) ?
                                     EXPECTED_PERIOD - TOLERANCE : 0;
    localparam int unsigned HI_P   = EXPECTED_PERIOD + TOLERANCE;

    localparam logic [CNT_W-1:0] LO_BOUND  = CNT_W'(LO_P);
    localparam logic [CNT_W-1:0] HI_BOUND  = CNT_W'(HI_P);
    localparam logic [CNT_W-1:0] TMO_COUNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StLocked,
        StLost
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    level_q;     // synchronised level, aligned with the pulses
    logic                    rise_q, fall_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [GOOD_W-1:0]       good_q, good_d, good_inc;
    logic [CNT_W-1:0]        period_q, period_d;
    logic                    pv_q, pv_d;
    logic                    locked_q, locked_d;
    logic                    stuck_q, stuck_d;
    logic                    in_range;
    logic                    timed_out;
    logic                    sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Edge detect is registered so a div_in change shows up SYNC_STAGES+1 cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else if (clear) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], div_in};
            level_q <= sync_last;
            rise_q  <= sync_last & ~level_q;
            fall_q  <= ~sync_last & level_q;
        end
    end

    // Period counter: a rise loads 1 so that rises P cycles apart read back P.
    always_comb begin
        cnt_d = cnt_q;
        if (rise_q) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign in_range  = (cnt_q >= LO_BOUND) && (cnt_q <= HI_BOUND);
    assign timed_out = (cnt_q == TMO_COUNT);
    assign good_inc  = good_q + GOOD_W'(1);

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        period_d = period_q;
        pv_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise_q) begin
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                if (rise_q) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    if (in_range) begin
                        good_d = good_inc;
                        if (32'(good_inc) >= LOCK_COUNT) begin
                            state_d = StLocked;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timed_out) begin
                    state_d = StLost;
                    good_d  = '0;
                end
            end
            StLocked: begin
                if (rise_q) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    if (!in_range) begin
                        state_d = StMeasure;
                        good_d  = '0;
                    end
                end else if (timed_out) begin
                    state_d = StLost;
                    good_d  = '0;
                end
            end
            StLost: begin
                // Restart measurement; this rise has no valid previous edge.
                if (rise_q) begin
                    state_d = StMeasure;
                end
            end
            default: begin
                state_d = StIdle;
                good_d  = '0;
            end
        endcase
        locked_d = (state_d == StLocked);
        stuck_d  = (state_d == StLost);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            good_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            stuck_q  <= 1'b0;
        end else if (clear) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            good_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            stuck_q  <= stuck_d;
        end
    end

`ifdef DIV_CLK_MONITOR_DUTY_EN
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] high_q;

    // level_q is already high in the rise cycle, so the load of 1 covers that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else if (clear) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            if (rise_q) begin
                hcnt_q <= CNT_ONE;
            end else if (level_q && (hcnt_q != '1)) begin
                hcnt_q <= hcnt_q + CNT_ONE;
            end
            if (fall_q && (state_q != StIdle)) begin
                high_q <= hcnt_q;
            end
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign stuck        = stuck_q;

endmodule
